// File: rtl/regfile_scoreboard.sv
// Register file with per-register reservation scoreboard for an in-order pipeline.
// Decode reads two operands (with writeback bypass) and stalls on RAW/WAW hazards;
// writeback releases a reservation and optionally writes data. Protocol
// violations (double reserve, release of an unreserved register) set a sticky
// error flag. Register 0 is hardwired to zero and never participates.
module regfile_scoreboard #(
    parameter int W_OPR = 32,
    parameter int W_RD  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic [W_RD-1:0]  r0_i,
    input  logic [W_RD-1:0]  r1_i,
    output logic [W_OPR-1:0] opr0_o,
    output logic [W_OPR-1:0] opr1_o,
    output logic             reserved_o,
    input  logic             w_reserve_i,
    input  logic [W_RD-1:0]  wrsv_r_i,
    input  logic             wb_v_i,
    input  logic             wb_we_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] wb_data_i,
    output logic [W_RD:0]    rsv_cnt_o,
    output logic             err_o
);

    localparam int NREG = 2 ** W_RD;

    logic [W_OPR-1:0] regs [NREG];
    logic [NREG-1:0]  rsv;
    logic [NREG-1:0]  rsv_next;
    logic [NREG-1:0]  wb_dec;
    logic [NREG-1:0]  rsv_eff;
    logic             rel;
    logic             res;
    logic             set_evt;
    logic             clr_evt;
    logic             bad_reserve;
    logic             bad_release;

    // Register 0 is excluded from every release and reserve action
    assign rel = wb_v_i && (wb_r_i != '0);
    assign res = w_reserve_i && (wrsv_r_i != '0);

    // A same-cycle release hides the reservation it clears from the hazard check
    always_comb begin
        wb_dec = '0;
        for (int i = 0; i < NREG; i++) begin
            wb_dec[i] = wb_v_i && (wb_r_i == W_RD'(i));
        end
        rsv_eff = rsv & ~wb_dec;
    end

    // Hazard covers both sources (RAW) and the destination (WAW)
    assign reserved_o = v_i && (rsv_eff[r0_i] || rsv_eff[r1_i] || rsv_eff[wrsv_r_i]);

    // Operand read with writeback bypass; register 0 always reads zero
    always_comb begin
        opr0_o = '0;
        opr1_o = '0;
        if (r0_i != '0) begin
            opr0_o = (wb_v_i && wb_we_i && (wb_r_i == r0_i)) ? wb_data_i : regs[r0_i];
        end
        if (r1_i != '0) begin
            opr1_o = (wb_v_i && wb_we_i && (wb_r_i == r1_i)) ? wb_data_i : regs[r1_i];
        end
    end

    // Next reservation vector: release is applied first so a same-register reserve wins
    always_comb begin
        rsv_next = rsv;
        if (rel) begin
            rsv_next[wb_r_i] = 1'b0;
        end
        if (res) begin
            rsv_next[wrsv_r_i] = 1'b1;
        end
        set_evt     = |(rsv_next & ~rsv);
        clr_evt     = |(rsv & ~rsv_next);
        bad_reserve = res && rsv[wrsv_r_i] && !(rel && (wb_r_i == wrsv_r_i));
        bad_release = rel && !rsv[wb_r_i];
    end

    // Data storage: writeback writes any nonzero register, reset clears all
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (rel && wb_we_i) begin
            regs[wb_r_i] <= wb_data_i;
        end
    end

    // Reservation bits and their population count move together each edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rsv       <= '0;
            rsv_cnt_o <= '0;
        end else begin
            rsv       <= rsv_next;
            rsv_cnt_o <= rsv_cnt_o + {{W_RD{1'b0}}, set_evt} - {{W_RD{1'b0}}, clr_evt};
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_o <= 1'b0;
        end else if (bad_reserve || bad_release) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a table of directed vectors with
// hand-derived expectations, a reserve-all-then-reset sequence, and randomized
// traffic compared with a behavioural array model of the scoreboard.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic        v_i;
    logic [4:0]  r0_i;
    logic [4:0]  r1_i;
    logic [31:0] opr0_o;
    logic [31:0] opr1_o;
    logic        reserved_o;
    logic        w_reserve_i;
    logic [4:0]  wrsv_r_i;
    logic        wb_v_i;
    logic        wb_we_i;
    logic [4:0]  wb_r_i;
    logic [31:0] wb_data_i;
    logic [5:0]  rsv_cnt_o;
    logic        err_o;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic        wres;
        logic [4:0]  wrsv;
        logic        wbv;
        logic        wbwe;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic [31:0] e_opr0;
        logic [31:0] e_opr1;
        logic        e_res;
        int          e_cnt;
        logic        e_err;
    } vec_t;

    // Behavioural model state
    logic [31:0] m_reg [32];
    logic        m_rsv [32];
    logic        m_err;

    regfile_scoreboard #(.W_OPR(32), .W_RD(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .v_i         (v_i),
        .r0_i        (r0_i),
        .r1_i        (r1_i),
        .opr0_o      (opr0_o),
        .opr1_o      (opr1_o),
        .reserved_o  (reserved_o),
        .w_reserve_i (w_reserve_i),
        .wrsv_r_i    (wrsv_r_i),
        .wb_v_i      (wb_v_i),
        .wb_we_i     (wb_we_i),
        .wb_r_i      (wb_r_i),
        .wb_data_i   (wb_data_i),
        .rsv_cnt_o   (rsv_cnt_o),
        .err_o       (err_o)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_rsv[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] idx, vec_t v);
        if (idx == 0) return 32'd0;
        if (v.wbv && v.wbwe && v.wbr == idx) return v.wbd;
        return m_reg[idx];
    endfunction

    function automatic logic model_busy(logic [4:0] idx, vec_t v);
        return m_rsv[idx] && !(v.wbv && v.wbr == idx);
    endfunction

    // Fill the expected fields from the model's current state
    function automatic vec_t model_expect(vec_t v);
        vec_t e = v;
        e.e_opr0 = model_read(v.r0, v);
        e.e_opr1 = model_read(v.r1, v);
        e.e_res  = v.v && (model_busy(v.r0, v) || model_busy(v.r1, v) || model_busy(v.wrsv, v));
        e.e_cnt  = model_count();
        e.e_err  = m_err;
        return e;
    endfunction

    // Advance the model by one rising edge
    task automatic model_step(vec_t v);
        logic rel;
        logic res;
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 32'd0;
                m_rsv[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            rel = v.wbv && v.wbr != 0;
            res = v.wres && v.wrsv != 0;
            if (res && m_rsv[v.wrsv] && !(rel && v.wbr == v.wrsv)) m_err = 1'b1;
            if (rel && !m_rsv[v.wbr]) m_err = 1'b1;
            if (rel) begin
                m_rsv[v.wbr] = 1'b0;
                if (v.wbwe) m_reg[v.wbr] = v.wbd;
            end
            if (res) m_rsv[v.wrsv] = 1'b1;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        reset       = v.rst;
        v_i         = v.v;
        r0_i        = v.r0;
        r1_i        = v.r1;
        w_reserve_i = v.wres;
        wrsv_r_i    = v.wrsv;
        wb_v_i      = v.wbv;
        wb_we_i     = v.wbwe;
        wb_r_i      = v.wbr;
        wb_data_i   = v.wbd;
        #1;
    endtask

    task automatic checkOutput(vec_t v, string tag);
        check({tag, ".opr0"},     opr0_o,               v.e_opr0);
        check({tag, ".opr1"},     opr1_o,               v.e_opr1);
        check({tag, ".reserved"}, {31'd0, reserved_o},  {31'd0, v.e_res});
        check({tag, ".cnt"},      {26'd0, rsv_cnt_o},   v.e_cnt);
        check({tag, ".err"},      {31'd0, err_o},       {31'd0, v.e_err});
    endtask

    // One cycle: drive, optionally compare, then clock the model with the DUT
    task automatic run_vec(vec_t v, logic do_check, string tag);
        applyStimulus(v);
        if (do_check) checkOutput(v, tag);
        @(posedge clk);
        model_step(v);
    endtask

    function automatic vec_t mk(logic rst, logic v, logic [4:0] r0, logic [4:0] r1,
                                logic wres, logic [4:0] wrsv, logic wbv, logic wbwe,
                                logic [4:0] wbr, logic [31:0] wbd,
                                logic [31:0] eo0, logic [31:0] eo1, logic eres,
                                int ecnt, logic eerr);
        vec_t t;
        t.rst = rst; t.v = v; t.r0 = r0; t.r1 = r1; t.wres = wres; t.wrsv = wrsv;
        t.wbv = wbv; t.wbwe = wbwe; t.wbr = wbr; t.wbd = wbd;
        t.e_opr0 = eo0; t.e_opr1 = eo1; t.e_res = eres; t.e_cnt = ecnt; t.e_err = eerr;
        return t;
    endfunction

    vec_t tbl [$];

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        reset = 1'b0; v_i = 1'b0; r0_i = '0; r1_i = '0; w_reserve_i = 1'b0; wrsv_r_i = '0;
        wb_v_i = 1'b0; wb_we_i = 1'b0; wb_r_i = '0; wb_data_i = '0;

        // Directed table: expectations are pre-edge outputs for each cycle
        //            rst v  r0  r1  wres wrsv wbv we wbr wbd           opr0          opr1          res cnt err
        tbl.push_back(mk(0, 1,  3,  7, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  5,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1,  5,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 1,  5,  0, 0,  0,  1, 1,  5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 1,  5,  5, 0,  0,  0, 0,  0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  9,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1,  9,  0, 1,  9,  1, 0,  9, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 1,  9,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 1,  0,  9, 1,  0,  1, 1,  0, 32'h1234,     32'h0,        32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 0,  0,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 0,  0,  0, 1,  4,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 1,  4,  0, 1,  4,  0, 0,  0, 32'h0,        32'h0,        32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 0,  0,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 2, 1));
        tbl.push_back(mk(0, 1,  6,  0, 0,  0,  1, 1,  6, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0, 2, 1));
        tbl.push_back(mk(1, 0,  0,  0, 1,  7,  1, 1,  8, 32'h77,       32'h0,        32'h0,        0, 2, 1));
        tbl.push_back(mk(0, 1,  5,  6, 0,  9,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1,  7,  8, 0,  4,  1, 0,  6, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0,  0,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk(1, 0,  0,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 1));
        tbl.push_back(mk(0, 0,  0,  0, 1,  3,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(1, 1,  3,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        1, 1, 0));
        tbl.push_back(mk(0, 1,  3,  0, 0,  0,  1, 0,  3, 32'h0,        32'h0,        32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0,  0,  0, 0,  0,  0, 0,  0, 32'h0,        32'h0,        32'h0,        0, 0, 1));

        // Initial reset, not checked: outputs are undefined before the first edge
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0), 1'b0, "init");
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Reserve r1..r31 one per cycle, then reset and confirm nothing stays busy
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0), 1'b0, "rst");
        for (int i = 1; i < 32; i++) begin
            run_vec(mk(0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, i - 1, 0), 1'b1,
                    $sformatf("fill%0d", i));
        end
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 31, 0), 1'b1, "full");
        for (int i = 0; i < 32; i++) begin
            run_vec(mk(0, 1, 5'(i), 5'(i), 0, 5'(i), 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0), 1'b1,
                    $sformatf("clr%0d", i));
        end

        // Randomized traffic against the model, with periodic resets
        for (int n = 0; n < 600; n++) begin
            v.rst  = (n % 50 == 49);
            v.v    = 1'($urandom_range(0, 1));
            v.r0   = 5'($urandom_range(0, 9));
            v.r1   = 5'($urandom_range(0, 9));
            v.wres = ($urandom_range(0, 2) == 0);
            v.wrsv = 5'($urandom_range(0, 9));
            v.wbv  = ($urandom_range(0, 2) == 0);
            v.wbwe = 1'($urandom_range(0, 1));
            v.wbr  = 5'($urandom_range(0, 9));
            v.wbd  = $urandom;
            v = model_expect(v);
            run_vec(v, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
